// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction-memory interface. Takes a program image as a
//   UART byte stream, assembles big-endian 32-bit words and writes them
//   sequentially into the instruction RAM. The CPU is held in reset while the
//   image is loading. A trailing XOR checksum decides between done and error.
//
//   Frame: CNT_HI, CNT_LO (16-bit word count N, big-endian),
//          N x 4 data bytes (each word big-endian), 1 checksum byte
//          (XOR of all data bytes; count bytes are not included).
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   load_req   one-cycle start pulse, honoured only in IDLE
//   rx_data    received byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   wr_en      instruction RAM write strobe, one cycle per word
//   wr_addr    word address being written
//   wr_data    instruction word being written
//   cpu_hold   keeps the CPU/PC in reset while high
//   load_done  one-cycle pulse on successful completion
//   load_err   sticky error flag, cleared by the next accepted load_req
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int Inst_Num     = 150,
    parameter int Inst_Num_BIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_req,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    wr_en,
    output logic [Inst_Num_BIT-1:0] wr_addr,
    output logic [31:0]             wr_data,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    load_err,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic [23:0] word_sr;   // first three bytes of the word being assembled

    logic [15:0] cnt_next;
    logic        cnt_bad;
    logic        last_word;

    // Count as it will be once the low byte lands; judged in the same cycle.
    assign cnt_next  = {word_cnt[15:8], rx_data};
    assign cnt_bad   = (cnt_next == 16'd0) || (cnt_next > 16'(Inst_Num));
    // 16-bit compare so an address can never be mistaken for N-1 by truncation.
    assign last_word = (16'(wr_addr) == (word_cnt - 16'd1));

    // ------------------------------------------------------------------ state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load_req) state_d = S_CNT_HI;
            S_CNT_HI: if (rx_valid) state_d = S_CNT_LO;
            S_CNT_LO: if (rx_valid) state_d = cnt_bad ? S_ERR : S_DATA;
            S_DATA:   if (rx_valid && byte_idx == 2'd3) state_d = S_WRITE;
            S_WRITE:  state_d = last_word ? S_CHECK : S_DATA;
            S_CHECK:  if (rx_valid) state_d = (rx_data == csum) ? S_DONE : S_ERR;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            byte_idx <= '0;
            csum     <= '0;
            word_sr  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            load_err <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_req) begin
                        load_err <= 1'b0;
                        csum     <= '0;
                        wr_addr  <= '0;
                        byte_idx <= '0;
                    end
                end
                S_CNT_HI: if (rx_valid) word_cnt[15:8] <= rx_data;
                S_CNT_LO: begin
                    if (rx_valid) begin
                        word_cnt[7:0] <= rx_data;
                        byte_idx      <= '0;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        csum     <= csum ^ rx_data;
                        // 2-bit index wraps to 0 after the 4th byte, ready for the next word.
                        byte_idx <= byte_idx + 2'd1;
                        // wr_data is only loaded when the word is complete so it
                        // stays stable outside WRITE.
                        if (byte_idx == 2'd3) wr_data <= {word_sr, rx_data};
                        else                  word_sr <= {word_sr[15:0], rx_data};
                    end
                end
                S_WRITE: begin
                    if (!last_word) wr_addr <= wr_addr + 1'b1;
                end
                S_ERR:   load_err <= 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign wr_en     = (state_q == S_WRITE);
    assign load_done = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign cpu_hold  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                       (state_q == S_DATA)   || (state_q == S_WRITE)  ||
                       (state_q == S_CHECK);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold, load_done, load_err, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          done_cnt;
    logic [31:0] wq[$];

    imem_loader #(.Inst_Num(150), .Inst_Num_BIT(8)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .load_req (load_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Write / done monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    // All stimulus tasks start and end on a negedge.
    task automatic strobe(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        strobe(b);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Full frame from the words queued in wq.
    task automatic load_frame(input logic [15:0] n, input logic [7:0] cs);
        clear_log();
        pulse_req();
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        foreach (wq[i]) send_word(wq[i]);
        send_byte(cs);
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        done_cnt = 0;
        repeat (3) @(negedge clk);

        // ---- reset state
        check("rst_wr_en",    wr_en,     0);
        check("rst_wr_addr",  wr_addr,   0);
        check("rst_wr_data",  wr_data,   0);
        check("rst_cpu_hold", cpu_hold,  0);
        check("rst_done",     load_done, 0);
        check("rst_err",      load_err,  0);
        check("rst_busy",     busy,      0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- good 2-word load; checksum = 0x28 (the 0x61/0x65 pairs cancel)
        clear_log();
        pulse_req();
        check("t1_hold_after_req", cpu_hold, 1);
        check("t1_busy_after_req", busy, 1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h3C);
        send_byte(8'h01);
        send_byte(8'h61);
        strobe(8'h65);
        check("t1_wr_en_latency", wr_en, 1);
        check("t1_wr_addr0", wr_addr, 0);
        check("t1_wr_data0", wr_data, 32'h3C016165);
        @(negedge clk);
        check("t1_wr_en_one_cycle", wr_en, 0);
        check("t1_wr_data_stable", wr_data, 32'h3C016165);
        @(negedge clk);
        send_byte(8'h34);
        pulse_req();                       // load_req while busy: ignored
        send_byte(8'h21);
        send_byte(8'h61);
        send_byte(8'h65);
        check("t1_hold_in_check", cpu_hold, 1);
        check("t1_addr_not_past_last", wr_addr, 1);
        strobe(8'h28);
        check("t1_done_pulse", load_done, 1);
        check("t1_hold_dropped", cpu_hold, 0);
        @(negedge clk);
        check("t1_done_one_cycle", load_done, 0);
        check("t1_idle", busy, 0);
        check("t1_err", load_err, 0);
        check("t1_nwrites", log_addr.size(), 2);
        check("t1_addr1", log_addr[1], 1);
        check("t1_data1", log_data[1], 32'h34216165);
        check("t1_done_cnt", done_cnt, 1);

        // ---- bad checksum
        wq = '{32'h3C016165, 32'h34216165};
        load_frame(16'd2, 8'h1D);
        check("t2_nwrites", log_addr.size(), 2);
        check("t2_err", load_err, 1);
        check("t2_hold", cpu_hold, 0);
        check("t2_no_done", done_cnt, 0);

        // ---- count 0 and count 151
        wq = {};
        load_frame(16'd0, 8'h00);
        check("t3_cnt0_err", load_err, 1);
        check("t3_cnt0_nowr", log_addr.size(), 0);
        check("t3_cnt0_idle", busy, 0);
        clear_log();
        pulse_req();
        check("t3_err_cleared_by_req", load_err, 0);
        send_byte(8'h00);
        send_byte(8'h97);
        check("t3_cnt151_err", load_err, 1);
        check("t3_cnt151_nowr", log_addr.size(), 0);
        check("t3_cnt151_idle", busy, 0);
        wq = '{32'hDEADBEEF};
        load_frame(16'd1, 8'h22);
        check("t3_recover_err", load_err, 0);
        check("t3_recover_done", done_cnt, 1);
        check("t3_recover_data", log_data[0], 32'hDEADBEEF);

        // ---- full RAM: 150 zero words
        wq = {};
        for (int i = 0; i < 150; i++) wq.push_back(32'h0);
        load_frame(16'd150, 8'h00);
        bad = 0;
        foreach (log_addr[i]) if (log_addr[i] !== 8'(i) || log_data[i] !== 32'h0) bad++;
        check("t4_nwrites", log_addr.size(), 150);
        check("t4_seq_errors", bad, 0);
        check("t4_last_addr", log_addr[149], 149);
        check("t4_wr_addr_final", wr_addr, 149);
        check("t4_done", done_cnt, 1);
        check("t4_err", load_err, 0);

        // ---- reset mid-load after the 6th data byte
        clear_log();
        pulse_req();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        #2 rst_n = 1'b0;
        #1;
        check("t5_wr_en",    wr_en,     0);
        check("t5_wr_addr",  wr_addr,   0);
        check("t5_wr_data",  wr_data,   0);
        check("t5_cpu_hold", cpu_hold,  0);
        check("t5_done",     load_done, 0);
        check("t5_err",      load_err,  0);
        check("t5_busy",     busy,      0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wq = '{32'h11223344, 32'h55667788};
        load_frame(16'd2, 8'h88);
        check("t5_reload_n", log_addr.size(), 2);
        check("t5_reload_addr0", log_addr[0], 0);
        check("t5_reload_data1", log_data[1], 32'h55667788);
        check("t5_reload_done", done_cnt, 1);

        // ---- stray bytes in IDLE
        clear_log();
        send_byte(8'hAA);
        send_byte(8'h00);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_hold", cpu_hold, 0);
        check("t6_idle_nowr", log_addr.size(), 0);
        wq = '{32'hDEADBEEF};
        load_frame(16'd1, 8'h22);
        check("t6_after_done", done_cnt, 1);
        check("t6_after_addr", log_addr[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
